dm_arbiter: RTL and testbench
=============================

# dm_arbiter

Two-requester arbiter that shares the single-port synchronous data memory between the SISC CPU datapath (LOD/STR traffic) and a DMA/program-loader port. It sits between the requesters and the data memory. It serialises accesses, applies round-robin fairness, and returns registered read data with a one-cycle acknowledge pulse. The CPU control FSM treats `cpu_ack` as its memory-stage completion signal.

## Interface
- `ADDR_W`, 16, data-memory address width
- `DATA_W`, 32, data word width

Ports:
- `clk`  in  1  system clock, rising edge
- `rst_f`  in  1  reset; asynchronous, active-low
- `cpu_req`  in  1  CPU access request, level, held until `cpu_ack`
- `cpu_we`  in  1  1 = write, 0 = read
- `cpu_addr`  in  ADDR_W  CPU address
- `cpu_wdata`  in  DATA_W  CPU write data
- `cpu_ack`  out  1  one-cycle completion pulse
- `cpu_rdata`  out  DATA_W  read data, valid while `cpu_ack`=1
- `dma_req`, `dma_we`, `dma_addr`, `dma_wdata`, `dma_ack`, `dma_rdata`: same as the CPU ports, for the DMA side
- `mem_en`  out  1  memory access strobe
- `mem_we`  out  1  memory write enable; only ever 1 while `mem_en`=1
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  memory read data, valid the cycle after `mem_en`
- `busy`  out  1  1 in any state other than IDLE

## Operation
- FSM states: IDLE → ACCESS → RESP → IDLE. The default and unreachable encodings go to IDLE.
- **IDLE**
  - Samples the masked requests: `req_x & ~ack_x`. A requester whose ack is high this cycle is ignored, so a request that has not yet been dropped is never granted twice.
  - Only one request is valid: that requester wins.
  - Both requests are valid: the requester not granted last wins. `last_grant` resets to DMA, so the CPU wins the first tie.
  - On a grant: latch the winner id, update `last_grant`, and register `mem_en`=1, `mem_we`, `mem_addr` and `mem_wdata` from the winner's inputs. Go to ACCESS.
- **ACCESS**
  - `mem_*` signals are driven for exactly this one cycle.
  - On exit, `mem_en` and `mem_we` go to 0. Go to RESP.
- **RESP**
  - On a read, capture `mem_rdata` into the winner's rdata register.
  - On a write, the winner's rdata register holds its previous value.
  - Assert the winner's ack for the next cycle only. Go to IDLE.
- The requester holds its req, we, addr and wdata stable from raising req until it samples ack=1.
- The loser's request stays pending and is granted in the next IDLE cycle in which it is unmasked.
- `mem_addr` and `mem_wdata` hold their last values when `mem_en`=0.
- A request whose inputs change mid-access is a protocol violation. The arbiter uses the values latched at grant.

## Timing
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Latency: request sampled at edge E0 (IDLE) → `mem_en` high in cycle E0–E1 → data sampled at E2 → ack high in cycle E2–E3.
- Ack is 3 cycles after the sampling edge.
- IDLE is entered at E2, with ack high in that cycle. The earliest next grant is at E3, so the back-to-back access rate is one every 3 cycles.
- Reset values (asynchronous, when `rst_f`=0):
  - state = IDLE, `last_grant` = DMA
  - `cpu_ack` = `dma_ack` = 0, `mem_en` = `mem_we` = 0, `busy` = 0
  - `mem_addr`, `mem_wdata`, `cpu_rdata`, `dma_rdata` = 0
- Reset mid-access aborts the access. No ack is issued for it. A `mem_we` pulse already past the memory edge is not undone.
- Simultaneous new requests in IDLE are resolved by round-robin as above. A single requester never waits more than one foreign access.

## Structure
- Shared package `sisc_pkg` holds:
  - the state encodings IDLE=2'd0, ACCESS=2'd1, RESP=2'd2
  - the grant ids GNT_CPU=1'b0, GNT_DMA=1'b1
  - the default ADDR_W and DATA_W
- Sub-module `rr_pick2`: combinational two-way round-robin picker.
  - Inputs: two masked requests and `last_grant`.
  - Outputs: `valid` and `winner`.
- Everything else is in `dm_arbiter`: the FSM, the output registers and the rdata capture.

## Test plan
- **Reset:** hold `rst_f`=0 mid-ACCESS → all outputs at reset values immediately, and FSM in IDLE after release with no ack.
- **CPU read:** `cpu_req`=1, `cpu_we`=0, `cpu_addr`=16'h0010, memory returns 32'hDEADBEEF → `mem_en`=1 one cycle later, `cpu_ack`=1 with `cpu_rdata`=32'hDEADBEEF three cycles after the sampling edge, `dma_ack` stays 0.
- **DMA write:** addr 16'h00FF, data 32'h12345678 → `mem_we`=1 with that addr and data for one cycle, `dma_ack` one pulse, `dma_rdata` unchanged.
- **Tie after reset:** both reqs raised together → CPU is granted first and DMA second. Then both re-raise together → CPU is granted first again, because `last_grant`=DMA.
- **Double-grant mask:** CPU holds req one cycle past ack → exactly one `mem_en` pulse for that request.
- **Starvation:** CPU re-requests continuously while DMA is pending → grants alternate CPU, DMA, CPU, and each ack arrives within 6 cycles of its request.

Source files
------------

// File: rtl/sisc_pkg.sv
// Shared types and defaults for the SISC data-memory arbiter.
package sisc_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic GNT_CPU = 1'b0;
  localparam logic GNT_DMA = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: on a tie the requester not granted last wins.
module rr_pick2
  import sisc_pkg::*;
(
  input  logic req_cpu_i,
  input  logic req_dma_i,
  input  logic last_grant_i,
  output logic valid_o,
  output logic winner_o
);

  always_comb begin
    valid_o  = req_cpu_i | req_dma_i;
    winner_o = GNT_CPU;
    if (req_cpu_i && req_dma_i) begin
      winner_o = (last_grant_i == GNT_CPU) ? GNT_DMA : GNT_CPU;
    end else if (req_dma_i) begin
      winner_o = GNT_DMA;
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// Serialises CPU and DMA accesses onto the single-port data memory with
// round-robin fairness, registered read data and a one-cycle ack pulse.
//
// state  | meaning
// IDLE   | sample masked requests, grant and launch the memory strobe
// ACCESS | mem_* driven for this one cycle
// RESP   | capture read data, raise the winner's ack for the next cycle
module dm_arbiter
  import sisc_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_f,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  state_e              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                winner_q, winner_d;
  logic                we_q, we_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                cpu_ack_q, cpu_ack_d;
  logic                dma_ack_q, dma_ack_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]   dma_rdata_q, dma_rdata_d;

  logic pick_valid;
  logic pick_winner;

  // A requester whose ack is still high has not yet dropped req; ignore it.
  rr_pick2 u_pick (
    .req_cpu_i    (cpu_req & ~cpu_ack_q),
    .req_dma_i    (dma_req & ~dma_ack_q),
    .last_grant_i (last_grant_q),
    .valid_o      (pick_valid),
    .winner_o     (pick_winner)
  );

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_DMA;
      winner_q     <= GNT_CPU;
      we_q         <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_ack_q    <= 1'b0;
      dma_ack_q    <= 1'b0;
      cpu_rdata_q  <= '0;
      dma_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      winner_q     <= winner_d;
      we_q         <= we_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_ack_q    <= cpu_ack_d;
      dma_ack_q    <= dma_ack_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dma_rdata_q  <= dma_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    winner_d     = winner_q;
    we_d         = we_q;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    cpu_ack_d    = 1'b0;
    dma_ack_d    = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    dma_rdata_d  = dma_rdata_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          winner_d     = pick_winner;
          last_grant_d = pick_winner;
          mem_en_d     = 1'b1;
          if (pick_winner == GNT_DMA) begin
            we_d        = dma_we;
            mem_addr_d  = dma_addr;
            mem_wdata_d = dma_wdata;
          end else begin
            we_d        = cpu_we;
            mem_addr_d  = cpu_addr;
            mem_wdata_d = cpu_wdata;
          end
          mem_we_d = we_d;
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        state_d = RESP;
      end
      RESP: begin
        if (winner_q == GNT_DMA) begin
          dma_ack_d = 1'b1;
          if (!we_q) dma_rdata_d = mem_rdata;
        end else begin
          cpu_ack_d = 1'b1;
          if (!we_q) cpu_rdata_d = mem_rdata;
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign cpu_ack   = cpu_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dma_ack   = dma_ack_q;
  assign dma_rdata = dma_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a small synchronous memory model.
module tb_dm_arbiter;

  logic        clk = 1'b0;
  logic        rst_f;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [15:0] cpu_addr, dma_addr;
  logic [31:0] cpu_wdata, dma_wdata;
  logic        cpu_ack, dma_ack;
  logic [31:0] cpu_rdata, dma_rdata;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        busy;

  always #5 clk = ~clk;

  dm_arbiter dut (
    .clk       (clk),
    .rst_f     (rst_f),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .dma_req   (dma_req),
    .dma_we    (dma_we),
    .dma_addr  (dma_addr),
    .dma_wdata (dma_wdata),
    .dma_ack   (dma_ack),
    .dma_rdata (dma_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  // memory model, preloaded on the first clock edge
  logic [31:0] mem [0:255];
  bit          mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
      mem[8'h10] <= 32'hDEADBEEF;
      mem_init   <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[7:0]];
    end
  end

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int en_cnt = 0;
  int ack_cnt = 0;
  bit log_on = 1'b0;
  logic [15:0] grants[$];
  int cpu_acks[$];
  int dma_acks[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_en) en_cnt++;
    if (cpu_ack || dma_ack) ack_cnt++;
    if (log_on && mem_en) grants.push_back(mem_addr);
    if (log_on && cpu_ack) cpu_acks.push_back(cyc);
    if (log_on && dma_ack) dma_acks.push_back(cyc);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  int e0, a0, t_cpu, t_dma;

  initial begin
    rst_f = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
    tick(2);
    check("rst_ctl", {cpu_ack, dma_ack, mem_en, mem_we, busy}, 5'b0);
    check("rst_bus", {mem_addr, mem_wdata}, 48'h0);
    check("rst_rdata", {cpu_rdata, dma_rdata}, 64'h0);
    rst_f = 1'b1;
    tick(1);

    // reset in the middle of an access
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0044; cpu_wdata = 32'h0000AA55;
    tick(1);
    check("abort_pre", {mem_en, mem_we, busy}, 3'b111);
    a0 = ack_cnt;
    rst_f = 1'b0;
    #1;
    check("abort_ctl", {cpu_ack, dma_ack, mem_en, mem_we, busy}, 5'b0);
    check("abort_bus", {mem_addr, mem_wdata}, 48'h0);
    cpu_req = 0;
    tick(2);
    rst_f = 1'b1;
    tick(4);
    check("abort_no_ack", ack_cnt - a0, 0);
    check("abort_idle", busy, 1'b0);

    // CPU read
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
    tick(1);
    check("rd_strobe", {mem_en, mem_we, busy}, 3'b101);
    check("rd_addr", mem_addr, 16'h0010);
    tick(1);
    check("rd_en_off", mem_en, 1'b0);
    tick(1);
    check("rd_ack", {cpu_ack, dma_ack}, 2'b10);
    check("rd_data", cpu_rdata, 32'hDEADBEEF);
    cpu_req = 0;
    tick(1);
    check("rd_ack_pulse", {cpu_ack, busy}, 2'b00);

    // DMA write
    dma_req = 1; dma_we = 1; dma_addr = 16'h00FF; dma_wdata = 32'h12345678;
    tick(1);
    check("wr_strobe", {mem_en, mem_we}, 2'b11);
    check("wr_bus", {mem_addr, mem_wdata}, {16'h00FF, 32'h12345678});
    tick(1);
    check("wr_off", {mem_en, mem_we}, 2'b00);
    check("wr_hold", {mem_addr, mem_wdata}, {16'h00FF, 32'h12345678});
    tick(1);
    check("wr_ack", {cpu_ack, dma_ack}, 2'b01);
    check("wr_rdata_keep", dma_rdata, 32'h0);
    check("wr_cpu_rdata_keep", cpu_rdata, 32'hDEADBEEF);
    dma_req = 0; dma_we = 0;
    tick(1);
    check("wr_ack_pulse", dma_ack, 1'b0);
    check("wr_mem", mem[8'hFF], 32'h12345678);

    // tie after reset, twice
    rst_f = 1'b0;
    #1;
    rst_f = 1'b1;
    tick(1);
    for (int r = 0; r < 2; r++) begin
      cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
      dma_req = 1; dma_we = 0; dma_addr = 16'h00FF;
      tick(1);
      check($sformatf("tie%0d_first", r), {mem_en, mem_addr}, {1'b1, 16'h0010});
      tick(2);
      check($sformatf("tie%0d_cpu_ack", r), {cpu_ack, dma_ack}, 2'b10);
      cpu_req = 0;
      tick(1);
      check($sformatf("tie%0d_second", r), {mem_en, mem_addr}, {1'b1, 16'h00FF});
      tick(2);
      check($sformatf("tie%0d_dma_ack", r), {cpu_ack, dma_ack}, 2'b01);
      check($sformatf("tie%0d_dma_rdata", r), dma_rdata, 32'h12345678);
      dma_req = 0;
      tick(1);
    end

    // requester keeps req high through its ack cycle
    e0 = en_cnt;
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0050; cpu_wdata = 32'hCAFE0001;
    tick(3);
    check("dbl_ack", cpu_ack, 1'b1);
    tick(1);
    check("dbl_ack_low", cpu_ack, 1'b0);
    cpu_req = 0; cpu_we = 0;
    tick(4);
    check("dbl_one_strobe", en_cnt - e0, 1);
    check("dbl_mem", mem[8'h50], 32'hCAFE0001);

    // CPU requests continuously while DMA is pending
    log_on = 1'b1;
    t_cpu = cyc;
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0020;
    tick(1);
    t_dma = cyc;
    dma_req = 1; dma_we = 0; dma_addr = 16'h0030;
    tick(16);
    log_on = 1'b0;
    cpu_req = 0; dma_req = 0;
    tick(4);
    check("starve_n_grants", grants.size() >= 4, 1'b1);
    check("starve_g0", grants[0], 16'h0020);
    check("starve_g1", grants[1], 16'h0030);
    check("starve_g2", grants[2], 16'h0020);
    check("starve_g3", grants[3], 16'h0030);
    check("starve_cpu_lat", cpu_acks[0] - t_cpu, 3);
    check("starve_dma_lat", (dma_acks[0] - t_dma) <= 6, 1'b1);
    check("starve_cpu_period", cpu_acks[1] - cpu_acks[0], 6);
    check("starve_dma_period", dma_acks[1] - dma_acks[0], 6);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
